// File: rtl/velocity_mailbox_reader.sv
// Per-bot velocity mailboxes with round-robin reader onto a valid/ready stream.
// Controller posts fill empty slots; each consumed pair returns its slot to empty.
module velocity_mailbox_reader #(
  parameter int unsigned NUM_BOTS = 3,
  parameter int unsigned DW       = 16,
  parameter int unsigned FRAC     = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_bot,
  input  logic [DW-1:0]       wr_vx,
  input  logic [DW-1:0]       wr_vy,
  output logic                wr_drop,
  output logic [NUM_BOTS-1:0] mbox_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_bot,
  output logic [DW-1:0]       out_vx,
  output logic [DW-1:0]       out_vy,
  output logic [7:0]          drop_count
);

  // Fixed-point format is opaque to this block; only sanity-check it.
  if (NUM_BOTS < 1 || NUM_BOTS > 4 || FRAC > DW) begin : g_param_err
    $error("velocity_mailbox_reader: bad NUM_BOTS/FRAC");
  end

  localparam logic [2:0] NumBots3 = 3'(NUM_BOTS);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e               state_q, state_d;
  logic [NUM_BOTS-1:0]  flag_q, flag_d;
  logic [DW-1:0]        slot_vx_q [NUM_BOTS];
  logic [DW-1:0]        slot_vx_d [NUM_BOTS];
  logic [DW-1:0]        slot_vy_q [NUM_BOTS];
  logic [DW-1:0]        slot_vy_d [NUM_BOTS];
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_bot_q, out_bot_d;
  logic [DW-1:0]        out_vx_q, out_vx_d;
  logic [DW-1:0]        out_vy_q, out_vy_d;
  logic                 wr_drop_q, wr_drop_d;
  logic [7:0]           drop_count_q, drop_count_d;

  logic [3:0] flag_pad;
  logic       bot_in_range;
  logic       accept;
  logic       reject;
  logic       handshake;
  logic       found;
  logic [1:0] sel;
  logic [2:0] idx;

  assign mbox_ready = ~flag_q;
  assign out_valid  = out_valid_q;
  assign out_bot    = out_bot_q;
  assign out_vx     = out_vx_q;
  assign out_vy     = out_vy_q;
  assign wr_drop    = wr_drop_q;
  assign drop_count = drop_count_q;

  // Zero-padded so out-of-range wr_bot indexes safely read as busy-free.
  always_comb begin
    flag_pad = '0;
    flag_pad[NUM_BOTS-1:0] = flag_q;
  end

  assign bot_in_range = ({1'b0, wr_bot} < NumBots3);
  assign accept       = wr_en & bot_in_range & ~flag_pad[wr_bot];
  assign reject       = wr_en & ~accept;
  assign handshake    = (state_q == StPresent) & out_valid_q & out_ready;

  // First fresh slot at or above rr_ptr, wrapping at NUM_BOTS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_BOTS; k++) begin
      idx = {1'b0, rr_ptr_q} + 3'(k);
      if (idx >= NumBots3) idx = idx - NumBots3;
      if (!found && flag_pad[idx[1:0]]) begin
        found = 1'b1;
        sel   = idx[1:0];
      end
    end
  end

  // A post to the slot being consumed sees flag=1 and is rejected, so set and
  // clear never target the same slot in one cycle.
  always_comb begin
    flag_d = flag_q;
    for (int i = 0; i < NUM_BOTS; i++) begin
      slot_vx_d[i] = slot_vx_q[i];
      slot_vy_d[i] = slot_vy_q[i];
      if (accept && wr_bot == 2'(i)) begin
        flag_d[i]    = 1'b1;
        slot_vx_d[i] = wr_vx;
        slot_vy_d[i] = wr_vy;
      end
      if (handshake && out_bot_q == 2'(i)) flag_d[i] = 1'b0;
    end
  end

  always_comb begin
    wr_drop_d    = reject;
    drop_count_d = drop_count_q;
    if (reject && drop_count_q != 8'hff) drop_count_d = drop_count_q + 8'd1;
  end

  // Reader FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Reader FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (found) state_d = StPresent;
      StPresent: if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Reader FSM: registered outputs and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bot_d   = out_bot_q;
    out_vx_d    = out_vx_q;
    out_vy_d    = out_vy_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          out_valid_d = 1'b1;
          out_bot_d   = sel;
          out_vx_d    = slot_vx_q[sel];
          out_vy_d    = slot_vy_q[sel];
        end
      end
      StPresent: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = ({1'b0, out_bot_q} == NumBots3 - 3'd1) ? 2'd0 : out_bot_q + 2'd1;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q       <= '0;
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_bot_q    <= '0;
      out_vx_q     <= '0;
      out_vy_q     <= '0;
      wr_drop_q    <= 1'b0;
      drop_count_q <= '0;
      for (int i = 0; i < NUM_BOTS; i++) begin
        slot_vx_q[i] <= '0;
        slot_vy_q[i] <= '0;
      end
    end else begin
      flag_q       <= flag_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_bot_q    <= out_bot_d;
      out_vx_q     <= out_vx_d;
      out_vy_q     <= out_vy_d;
      wr_drop_q    <= wr_drop_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < NUM_BOTS; i++) begin
        slot_vx_q[i] <= slot_vx_d[i];
        slot_vy_q[i] <= slot_vy_d[i];
      end
    end
  end

endmodule

// File: tb/tb_velocity_mailbox_reader.sv
// Bench for velocity_mailbox_reader: directed posts against a slot/queue model,
// compared every cycle, plus literal expectations for each scenario.
module tb_velocity_mailbox_reader;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bot = 2'd0;
  logic [15:0] wr_vx = 16'h0;
  logic [15:0] wr_vy = 16'h0;
  logic        out_ready = 1'b0;
  logic        wr_drop;
  logic [2:0]  mbox_ready;
  logic        out_valid;
  logic [1:0]  out_bot;
  logic [15:0] out_vx;
  logic [15:0] out_vy;
  logic [7:0]  drop_count;

  velocity_mailbox_reader #(.NUM_BOTS(3), .DW(16), .FRAC(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_bot    (wr_bot),
    .wr_vx     (wr_vx),
    .wr_vy     (wr_vy),
    .wr_drop   (wr_drop),
    .mbox_ready(mbox_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bot   (out_bot),
    .out_vx    (out_vx),
    .out_vy    (out_vy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int xfers[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: slot contents, one presented pair, and a pointer for fair scanning.
  bit          m_flag [4] = '{default: 1'b0};
  logic [15:0] m_vx   [4] = '{default: 16'h0};
  logic [15:0] m_vy   [4] = '{default: 16'h0};
  int          m_rr = 0;
  bit          m_valid = 1'b0;
  int          m_bot = 0;
  logic [15:0] m_ovx = 16'h0;
  logic [15:0] m_ovy = 16'h0;
  bit          m_drop = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    bit hs, acc;
    int b, s;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_flag[i] = 1'b0;
        m_vx[i] = 16'h0;
        m_vy[i] = 16'h0;
      end
      m_rr = 0; m_valid = 1'b0; m_bot = 0; m_ovx = 16'h0; m_ovy = 16'h0;
      m_drop = 1'b0; m_cnt = 0;
    end else begin
      hs  = m_valid && out_ready;
      b   = int'(wr_bot);
      acc = wr_en && (b < N) && !m_flag[b];
      m_drop = wr_en && !acc;
      if (m_drop && m_cnt < 255) m_cnt++;
      if (hs) begin
        m_flag[m_bot] = 1'b0;
        m_valid = 1'b0;
        m_rr = (m_bot + 1) % N;
      end else if (!m_valid) begin
        for (int k = 0; k < N; k++) begin
          s = (m_rr + k) % N;
          if (m_flag[s]) begin
            m_valid = 1'b1;
            m_bot = s;
            m_ovx = m_vx[s];
            m_ovy = m_vy[s];
            break;
          end
        end
      end
      if (acc) begin
        m_flag[b] = 1'b1;
        m_vx[b] = wr_vx;
        m_vy[b] = wr_vy;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] exp_ready;
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_ready[i] = ~m_flag[i];
      check("cyc_mbox_ready", 32'(mbox_ready), 32'(exp_ready));
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_wr_drop", 32'(wr_drop), 32'(m_drop));
      check("cyc_drop_count", 32'(drop_count), 32'(m_cnt));
      if (m_valid) begin
        check("cyc_out_bot", 32'(out_bot), 32'(m_bot));
        check("cyc_out_vx", 32'(out_vx), 32'(m_ovx));
        check("cyc_out_vy", 32'(out_vy), 32'(m_ovy));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) xfers.push_back(int'(out_bot));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [1:0] bot, input logic [15:0] vx, input logic [15:0] vy);
    wr_en = 1'b1; wr_bot = bot; wr_vx = vx; wr_vy = vy;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset_ready", 32'(mbox_ready), 32'h7);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_bot", 32'(out_bot), 32'h0);
    check("reset_vx", 32'(out_vx), 32'h0);
    check("reset_drops", 32'(drop_count), 32'h0);
    repeat (20) tick();
    check("idle_ready", 32'(mbox_ready), 32'h7);
    check("idle_valid", 32'(out_valid), 32'h0);

    // Single post: visible one cycle after acceptance.
    out_ready = 1'b1;
    post(2'd1, 16'h0400, 16'h0002);
    check("single_pending_ready", 32'(mbox_ready), 32'h5);
    check("single_not_yet_valid", 32'(out_valid), 32'h0);
    tick();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_bot", 32'(out_bot), 32'h1);
    check("single_vx", 32'(out_vx), 32'h0400);
    check("single_vy", 32'(out_vy), 32'h0002);
    tick();
    check("single_done_ready", 32'(mbox_ready), 32'h7);
    check("single_done_valid", 32'(out_valid), 32'h0);
    check("single_xfers", 32'(xfers.size()), 32'd1);

    // Backpressure.
    out_ready = 1'b0;
    base = xfers.size();
    post(2'd0, 16'h1234, 16'h5678);
    tick();
    check("bp_valid", 32'(out_valid), 32'h1);
    repeat (10) tick();
    check("bp_held_valid", 32'(out_valid), 32'h1);
    check("bp_held_vx", 32'(out_vx), 32'h1234);
    check("bp_held_vy", 32'(out_vy), 32'h5678);
    check("bp_ready", 32'(mbox_ready), 32'h6);
    check("bp_no_xfer", 32'(xfers.size()), 32'(base));
    out_ready = 1'b1;
    tick();
    check("bp_one_xfer", 32'(xfers.size()), 32'(base + 1));
    check("bp_flag0_clear", 32'(mbox_ready), 32'h7);
    repeat (3) tick();
    check("bp_still_one", 32'(xfers.size()), 32'(base + 1));

    // Rejects: busy slot and out-of-range index.
    out_ready = 1'b0;
    post(2'd2, 16'hAAAA, 16'h1111);
    post(2'd2, 16'hBBBB, 16'h2222);
    check("rej_pulse1", 32'(wr_drop), 32'h1);
    post(2'd3, 16'hCCCC, 16'h3333);
    check("rej_pulse2", 32'(wr_drop), 32'h1);
    tick();
    check("rej_pulse_end", 32'(wr_drop), 32'h0);
    check("rej_count", 32'(drop_count), 32'd2);
    check("rej_bot", 32'(out_bot), 32'h2);
    check("rej_first_vx", 32'(out_vx), 32'hAAAA);
    check("rej_first_vy", 32'(out_vy), 32'h1111);
    out_ready = 1'b1;
    repeat (2) tick();

    // Round-robin burst, then fairness with rr_ptr past the lower slot.
    base = xfers.size();
    post(2'd0, 16'h0010, 16'h0020);
    post(2'd1, 16'h0011, 16'h0021);
    post(2'd2, 16'h0012, 16'h0022);
    repeat (6) tick();
    check("rr_count", 32'(xfers.size()), 32'(base + 3));
    if (xfers.size() == base + 3) begin
      check("rr_first", 32'(xfers[base]), 32'd0);
      check("rr_second", 32'(xfers[base + 1]), 32'd1);
      check("rr_third", 32'(xfers[base + 2]), 32'd2);
    end
    out_ready = 1'b0;
    base = xfers.size();
    post(2'd1, 16'h0101, 16'h0201);
    post(2'd0, 16'h0100, 16'h0200);
    post(2'd2, 16'h0102, 16'h0202);
    out_ready = 1'b1;
    repeat (8) tick();
    check("fair_count", 32'(xfers.size()), 32'(base + 3));
    if (xfers.size() == base + 3) begin
      check("fair_first", 32'(xfers[base]), 32'd1);
      check("fair_second", 32'(xfers[base + 1]), 32'd2);
      check("fair_third", 32'(xfers[base + 2]), 32'd0);
    end

    // Post to the slot being consumed in the same cycle: clear wins.
    out_ready = 1'b0;
    post(2'd0, 16'h0700, 16'h0701);
    tick();
    out_ready = 1'b1;
    post(2'd0, 16'h0800, 16'h0801);
    check("clash_drop", 32'(wr_drop), 32'h1);
    check("clash_count", 32'(drop_count), 32'd3);
    check("clash_ready", 32'(mbox_ready), 32'h7);
    tick();
    check("clash_idle", 32'(out_valid), 32'h0);

    // Asynchronous reset while presenting with two slots pending.
    out_ready = 1'b0;
    post(2'd0, 16'h0A00, 16'h0A01);
    post(2'd1, 16'h0B00, 16'h0B01);
    check("arst_pre_valid", 32'(out_valid), 32'h1);
    check("arst_pre_ready", 32'(mbox_ready), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_ready", 32'(mbox_ready), 32'h7);
    check("arst_drops", 32'(drop_count), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    base = xfers.size();
    out_ready = 1'b1;
    repeat (5) tick();
    check("arst_no_xfer", 32'(xfers.size()), 32'(base));
    check("arst_still_idle", 32'(out_valid), 32'h0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
